// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes R-type shift funct into barrel-shifter controls.
// Latency: accept in cycle N -> out_valid in cycle N+1; one entry per cycle when out_ready is held.
// Backpressure: registered 2-entry skid buffer; in_ready drops only when both entries are occupied.
module shift_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic [4:0]       rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      x,
  output logic [4:0]       sa,
  output logic             arith,
  output logic             right,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] shift_count
);

  typedef struct packed {
    logic [31:0] x;
    logic [4:0]  sa;
    logic        arith;
    logic        right;
    logic [4:0]  rd;
    logic        illegal;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state;
  ent_t   dec;
  ent_t   main_q;
  ent_t   skid_q;
  logic   accept;
  logic   issue;

  // Only the low five bits of rs select the variable shift amount.
  logic unused_rs_hi;
  assign unused_rs_hi = ^rs_data[31:5];

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

  // Decode the funct field into shifter controls on the input side.
  always_comb begin
    dec         = '0;
    dec.x       = rt_data;
    dec.rd      = rd;
    case (funct)
      6'b000000: dec.sa = shamt;
      6'b000010: begin dec.sa = shamt;        dec.right = 1'b1; end
      6'b000011: begin dec.sa = shamt;        dec.right = 1'b1; dec.arith = 1'b1; end
      6'b000100: dec.sa = rs_data[4:0];
      6'b000110: begin dec.sa = rs_data[4:0]; dec.right = 1'b1; end
      6'b000111: begin dec.sa = rs_data[4:0]; dec.right = 1'b1; dec.arith = 1'b1; end
      default:   dec.illegal = 1'b1;
    endcase
  end

  // Occupancy FSM for the main/skid pair; flush beats any same-cycle accept or issue.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q    <= dec;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (issue && accept) begin
            main_q <= dec;
          end else if (issue) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (accept) begin
            skid_q   <= dec;
            in_ready <= 1'b0;
            state    <= FULL;
          end
        end
        FULL: begin
          if (issue) begin
            main_q   <= skid_q;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Count issued legal shifts, saturating; flushed issues are not counted.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shift_count <= '0;
    end else if (!flush && issue && !main_q.illegal && (shift_count != {CNT_W{1'b1}})) begin
      shift_count <= shift_count + 1'b1;
    end
  end

  assign x           = main_q.x;
  assign sa          = main_q.sa;
  assign arith       = main_q.arith;
  assign right       = main_q.right;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage with a decode model and in-order scoreboard.
// Stimulus changes 1ns after the falling edge; the scoreboard samples handshakes 3ns after it.
// Counter is built 2 bits wide so saturation is reachable quickly.
module tb_shift_issue_stage;

  localparam int CNT_W = 2;

  typedef struct packed {
    logic [31:0] x;
    logic [4:0]  sa;
    logic        arith;
    logic        right;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             clrn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [4:0]       shamt;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic [4:0]       rd;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      x;
  logic [4:0]       sa;
  logic             arith;
  logic             right;
  logic [4:0]       out_rd;
  logic             out_illegal;
  logic [CNT_W-1:0] shift_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   exp_cnt = 0;

  shift_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .shamt(shamt), .rs_data(rs_data), .rt_data(rt_data), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .sa(sa), .arith(arith), .right(right), .out_rd(out_rd),
    .out_illegal(out_illegal), .shift_count(shift_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] d);
    exp_t m;
    m = '0;
    m.x  = rt;
    m.rd = d;
    case (f)
      6'd0:    m.sa = sh;
      6'd2:    begin m.sa = sh; m.right = 1'b1; end
      6'd3:    begin m.sa = sh; m.right = 1'b1; m.arith = 1'b1; end
      6'd4:    m.sa = rs[4:0];
      6'd6:    begin m.sa = rs[4:0]; m.right = 1'b1; end
      6'd7:    begin m.sa = rs[4:0]; m.right = 1'b1; m.arith = 1'b1; end
      default: m.ill = 1'b1;
    endcase
    return m;
  endfunction

  // Scoreboard: push on accept, pop and compare on issue, in the same cycle order as the DUT.
  always @(negedge clk) begin
    #3;
    if (!clrn) begin
      sb.delete();
      exp_cnt = 0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_issue_expected", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_issue_payload", {x, sa, arith, right, out_rd, out_illegal}, e);
          if (!e.ill && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(funct, shamt, rs_data, rt_data, rd));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] d);
    in_valid = 1'b1;
    funct    = f;
    shamt    = sh;
    rs_data  = rs;
    rt_data  = rt;
    rd       = d;
  endtask

  initial begin
    clrn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct = '0; shamt = '0; rs_data = '0; rt_data = '0; rd = '0;
    #1 clrn = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_payload", {x, sa, arith, right, out_rd, out_illegal}, '0);
    chk("rst_count", shift_count, 0);
    #10 clrn = 1'b1;

    // Single sll, then it issues.
    cyc();
    drive(6'b000000, 5'd7, 32'h0, 32'h0000_0001, 5'd3);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("sll_valid", out_valid, 1'b1);
    chk("sll_x", x, 32'h0000_0001);
    chk("sll_sa_dir", {sa, right, arith}, {5'd7, 1'b0, 1'b0});
    cyc();
    chk("sll_count", shift_count, 1);
    chk("sll_drained", out_valid, 1'b0);

    // srav takes only the low five bits of rs.
    drive(6'b000111, 5'd0, 32'hFFFF_FFE4, 32'h8000_0000, 5'd9);
    cyc();
    in_valid = 1'b0;
    chk("srav_ctl", {sa, right, arith, out_illegal}, {5'd4, 1'b1, 1'b1, 1'b0});
    cyc();
    chk("srav_count", shift_count, 2);

    // Illegal funct: no shift amount, not counted.
    drive(6'b100000, 5'd5, 32'h0, 32'h1234_5678, 5'd1);
    cyc();
    in_valid = 1'b0;
    chk("ill_ctl", {out_illegal, sa, right}, {1'b1, 5'd0, 1'b0});
    cyc();
    chk("ill_count", shift_count, 2);

    // Fill both entries, then flush with a simultaneous accept and issue.
    out_ready = 1'b0;
    drive(6'b000000, 5'd2, 32'h0, 32'hA, 5'd4);
    cyc();
    drive(6'b000010, 5'd3, 32'h0, 32'hB, 5'd5);
    cyc();
    drive(6'b000011, 5'd4, 32'h0, 32'hC, 5'd6);
    chk("full_in_ready", in_ready, 1'b0);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_state", {out_valid, in_ready}, {1'b0, 1'b1});
    chk("flush_count", shift_count, 2);
    drive(6'b000000, 5'd1, 32'h0, 32'hD, 5'd7);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("post_flush_count", shift_count, 3);

    // Backpressure: three back-to-back entries while stalled.
    out_ready = 1'b0;
    drive(6'b000000, 5'd1, 32'h0, 32'h11, 5'd10);
    cyc();
    drive(6'b000010, 5'd2, 32'h0, 32'h22, 5'd11);
    chk("bp_ready_one", in_ready, 1'b1);
    cyc();
    drive(6'b000011, 5'd3, 32'h0, 32'h33, 5'd12);
    chk("bp_ready_full", in_ready, 1'b0);
    cyc();
    chk("bp_stall_hold", {out_valid, sa, right, x}, {1'b1, 5'd1, 1'b0, 32'h11});
    cyc();
    chk("bp_stall_hold2", {out_valid, sa, in_ready}, {1'b1, 5'd1, 1'b0});
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) break;
      cyc();
    end
    chk("bp_ready_back", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("bp_drained", sb.size(), 0);
    chk("bp_out_idle", out_valid, 1'b0);
    chk("sat_count_model", shift_count, exp_cnt);

    // Async reset between edges while stalled.
    out_ready = 1'b0;
    drive(6'b000011, 5'd9, 32'h0, 32'hFFFF_0000, 5'd13);
    cyc();
    in_valid = 1'b0;
    chk("ar_loaded", out_valid, 1'b1);
    #1 clrn = 1'b0;
    #1;
    chk("ar_state", {out_valid, in_ready}, {1'b0, 1'b1});
    chk("ar_payload", {x, sa, arith, right, out_rd, out_illegal}, '0);
    chk("ar_count", shift_count, 0);
    cyc();
    clrn = 1'b1;

    // Saturation: five legal issues on a 2-bit counter.
    cyc();
    out_ready = 1'b1;
    drive(6'b000100, 5'd0, 32'h3, 32'h5, 5'd2);
    for (int i = 0; i < 5; i++) cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("sat_count", shift_count, 3);
    chk("sat_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Pipeline stage directly upstream of the 32-bit barrel shifter in the CPU execute path.
- Accepts decoded R-type shift instructions (sll/srl/sra/sllv/srlv/srav) from the ID stage over a valid/ready handshake.
- Decodes the 6-bit funct field into shifter controls: operand X, 5-bit shift amount Sa, Arith, Right.
- Holds them in a registered 2-entry skid buffer so the shifter inputs are glitch-free and upstream ready is registered; also counts issued shifts.

Parameters:
- CNT_W, 16, width of saturating issued-shift counter

Ports:
- Clk  input  1  clock, rising edge
- Clrn  input  1  asynchronous active-low reset
- Flush  input  1  synchronous flush: drop all buffered entries
- In_Valid  input  1  upstream entry valid
- In_Ready  output  1  stage can accept (registered)
- Funct  input  6  R-type funct field
- Shamt  input  5  instruction shamt field
- Rs_Data  input  32  rs register value (variable shift amount source)
- Rt_Data  input  32  rt register value (operand to shift)
- Rd  input  5  destination register
- Out_Valid  output  1  shifter controls valid
- Out_Ready  input  1  downstream (EX/MEM) accepts
- X  output  32  operand to shifter
- Sa  output  5  shift amount to shifter
- Arith  output  1  arithmetic right shift
- Right  output  1  1 = right shift, 0 = left
- Out_Rd  output  5  destination register, aligned with X/Sa
- Out_Illegal  output  1  funct was not a shift op
- Shift_Count  output  CNT_W  issued legal shifts, saturating

Behaviour:
- Reset (Clrn=0, async): Out_Valid=0, In_Ready=1, X=0, Sa=0, Arith=0, Right=0, Out_Rd=0, Out_Illegal=0, Shift_Count=0; both buffer entries empty.
- Decode, combinational on input side, captured on accept:
  - 000000 sll: Sa=Shamt, Right=0, Arith=0.
  - 000010 srl: Sa=Shamt, Right=1, Arith=0.
  - 000011 sra: Sa=Shamt, Right=1, Arith=1.
  - 000100 sllv: Sa=Rs_Data[4:0], Right=0, Arith=0.
  - 000110 srlv: Sa=Rs_Data[4:0], Right=1, Arith=0.
  - 000111 srav: Sa=Rs_Data[4:0], Right=1, Arith=1.
  - Any other funct: Sa=0, Right=0, Arith=0, Out_Illegal=1.
  - X=Rt_Data always. Rs_Data[31:5] ignored.
- Handshakes:
  - Accept = In_Valid & In_Ready.
  - Issue = Out_Valid & Out_Ready.
  - All outputs are driven from the main register only; no combinational path from inputs to outputs.
  - Out_Valid, X, Sa, Arith, Right, Out_Rd, Out_Illegal stay stable while Out_Valid=1 and Out_Ready=0.
- Skid buffer, states by occupancy:
  - EMPTY:
    - accept -> main loads, Out_Valid=1 next cycle -> ONE.
  - ONE:
    - issue and no accept -> EMPTY.
    - issue and accept -> main reloads with new entry, stays ONE.
    - accept and no issue -> entry goes to skid, In_Ready=0 next cycle -> FULL.
  - FULL (In_Ready=0):
    - issue -> skid moves to main, In_Ready=1 next cycle -> ONE.
- Latency: accept in cycle N -> Out_Valid=1 in cycle N+1 (buffer EMPTY, or ONE with simultaneous issue). Throughput one entry per cycle with Out_Ready held 1.
- Flush, synchronous, highest priority: next cycle both entries empty, Out_Valid=0, In_Ready=1; any accept or issue in the same cycle is discarded and not counted.
- Shift_Count: +1 per issue with Out_Illegal=0; saturates at 2^CNT_W-1. Not cleared by Flush.
- Reset mid-operation clears everything immediately, independent of Clk.

Test Plan:
- Reset then single sll: Funct=000000, Shamt=7, Rt_Data=0x00000001, Out_Ready=1 -> next cycle Out_Valid=1, X=0x00000001, Sa=7, Right=0, Arith=0; Shift_Count=1 after issue.
- Variable srav: Funct=000111, Rs_Data=0xFFFFFFE4, Rt_Data=0x80000000 -> Sa=4 (low 5 bits only), Right=1, Arith=1, Out_Illegal=0.
- Backpressure: Out_Ready=0, three back-to-back In_Valid (sll 1, srl 2, sra 3) -> In_Ready falls after the second accept; third held upstream. Outputs stay sll/Sa=1 while stalled. Release Out_Ready -> issue order sll, srl, sra with no loss or duplication.
- Illegal funct 100000 with Shamt=5 -> Out_Illegal=1, Sa=0, Right=0; Shift_Count unchanged after issue.
- Flush while FULL -> next cycle Out_Valid=0, In_Ready=1; Shift_Count unchanged. Later legal issues count normally.
- Async reset asserted mid-stall, between clock edges -> outputs clear immediately. Counter saturation with CNT_W=2: 5 legal issues -> Shift_Count=3.
